// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the block-RAM backed line memory (bram_mem):
//   - default geometry of the wide, tagged memory protocol
//   - controller state encoding
//   - width helper for the per-line beat counter
// -----------------------------------------------------------------------------
package mem_pkg;

    // Default protocol geometry
    localparam int MEM_ADDR_BITS     = 26;   // line address width (byte address = addr * 64)
    localparam int MEM_TAG_BITS      = 5;    // transaction tag width
    localparam int MEM_DATA_BITS     = 128;  // beat width
    localparam int MEM_REFILL_CYCLES = 4;    // beats per line
    localparam int MEM_LINE_IDX_BITS = 10;   // log2 of stored lines

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } mem_state_e;

    // Width of a counter that indexes the beats of one line.
    // A one-beat line still gets a one-bit counter so the vector is never empty.
    function automatic int beat_bits(input int refill_cycles);
        if (refill_cycles <= 1) begin
            return 1;
        end else begin
            return $clog2(refill_cycles);
        end
    endfunction

endpackage : mem_pkg

// File: rtl/bram_mem.sv
// -----------------------------------------------------------------------------
// bram_mem
// Block-RAM backed backing store for the wide, tagged memory protocol. Every
// command addresses one cache line of REFILL_CYCLES beats. Reads stream the
// whole line back-to-back with the command's tag; writes consume the whole
// line from the write-data channel and produce no response.
//
// Ports
//   clk                 in   clock, rising-edge active
//   reset               in   asynchronous active-low reset
//   mem_req_valid       in   command valid
//   mem_req_ready       out  command ready (IDLE only)
//   mem_req_rw          in   1 = write, 0 = read
//   mem_req_addr        in   line address (upper bits alias)
//   mem_req_tag         in   transaction tag
//   mem_req_data_valid  in   write beat valid
//   mem_req_data_ready  out  write beat ready (WRITE only)
//   mem_req_data_bits   in   write beat data
//   mem_resp_valid      out  read beat valid, no backpressure
//   mem_resp_data       out  read beat data
//   mem_resp_tag        out  tag of the read being returned (holds when idle)
//
// The storage array "ram" is kept in this module so that it can be preloaded
// hierarchically; it is never cleared by reset.
// -----------------------------------------------------------------------------
module bram_mem
    import mem_pkg::*;
#(
    parameter int ADDR_BITS     = MEM_ADDR_BITS,
    parameter int TAG_BITS      = MEM_TAG_BITS,
    parameter int DATA_BITS     = MEM_DATA_BITS,
    parameter int REFILL_CYCLES = MEM_REFILL_CYCLES,
    parameter int LINE_IDX_BITS = MEM_LINE_IDX_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_req_valid,
    output logic                 mem_req_ready,
    input  logic                 mem_req_rw,
    input  logic [ADDR_BITS-1:0] mem_req_addr,
    input  logic [TAG_BITS-1:0]  mem_req_tag,
    input  logic                 mem_req_data_valid,
    output logic                 mem_req_data_ready,
    input  logic [DATA_BITS-1:0] mem_req_data_bits,
    output logic                 mem_resp_valid,
    output logic [DATA_BITS-1:0] mem_resp_data,
    output logic [TAG_BITS-1:0]  mem_resp_tag
);

    localparam int DEPTH_LINES   = 1 << LINE_IDX_BITS;
    localparam int DEPTH_WORDS   = DEPTH_LINES * REFILL_CYCLES;
    localparam int BEAT_BITS     = beat_bits(REFILL_CYCLES);
    localparam int WORD_IDX_BITS = LINE_IDX_BITS + BEAT_BITS;

    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(REFILL_CYCLES - 1);
    localparam logic [BEAT_BITS-1:0] BEAT_ONE  = BEAT_BITS'(1);
    localparam logic [BEAT_BITS-1:0] BEAT_ZERO = {BEAT_BITS{1'b0}};

    // Line storage; word index = {line index, beat}
    logic [DATA_BITS-1:0] ram [DEPTH_WORDS];

    // Controller registers
    mem_state_e             state_q, state_d;
    logic [BEAT_BITS-1:0]     beat_q, beat_d;
    logic [LINE_IDX_BITS-1:0] addr_q, addr_d;
    logic                     req_ready_q, req_ready_d;
    logic                     data_ready_q, data_ready_d;
    logic                     resp_valid_q, resp_valid_d;
    logic [TAG_BITS-1:0]      resp_tag_q, resp_tag_d;
    logic [DATA_BITS-1:0]     resp_data_q;

    // RAM port controls
    logic                     rd_en_s;
    logic [WORD_IDX_BITS-1:0] rd_idx_s;
    logic                     wr_en_s;
    logic [WORD_IDX_BITS-1:0] wr_idx_s;

    logic [LINE_IDX_BITS-1:0] req_line_s;
    logic [BEAT_BITS-1:0]     beat_nxt_s;

    // Only the low line-index bits select storage; the rest alias away.
    assign req_line_s = mem_req_addr[LINE_IDX_BITS-1:0];
    assign beat_nxt_s = beat_q + BEAT_ONE;

    logic unused_addr_bits_s;
    assign unused_addr_bits_s = ^mem_req_addr[ADDR_BITS-1:LINE_IDX_BITS];

    // Next-state, RAM port and output-register decode
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        addr_d       = addr_q;
        resp_valid_d = 1'b0;
        resp_tag_d   = resp_tag_q;
        rd_en_s      = 1'b0;
        rd_idx_s     = {addr_q, beat_nxt_s};
        wr_en_s      = 1'b0;
        wr_idx_s     = {addr_q, beat_q};

        case (state_q)
            IDLE: begin
                if (mem_req_valid && req_ready_q) begin
                    addr_d = req_line_s;
                    beat_d = BEAT_ZERO;
                    if (mem_req_rw) begin
                        state_d = WRITE;
                    end else begin
                        // Beat 0 is fetched on the accepting edge so the
                        // burst starts in the very next cycle.
                        state_d      = READ;
                        rd_en_s      = 1'b1;
                        rd_idx_s     = {req_line_s, BEAT_ZERO};
                        resp_valid_d = 1'b1;
                        resp_tag_d   = mem_req_tag;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            READ: begin
                // beat_q is the beat currently on the response bus.
                if (beat_q == LAST_BEAT) begin
                    state_d = IDLE;
                    beat_d  = BEAT_ZERO;
                end else begin
                    beat_d       = beat_nxt_s;
                    rd_en_s      = 1'b1;
                    resp_valid_d = 1'b1;
                end
            end

            WRITE: begin
                if (mem_req_data_valid && data_ready_q) begin
                    wr_en_s = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                        beat_d  = BEAT_ZERO;
                    end else begin
                        beat_d = beat_nxt_s;
                    end
                end else begin
                    state_d = WRITE;
                end
            end

            default: begin
                state_d = IDLE;
                beat_d  = BEAT_ZERO;
            end
        endcase

        req_ready_d  = (state_d == IDLE);
        data_ready_d = (state_d == WRITE);
    end

    // Controller state and registered handshake/response outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            beat_q       <= BEAT_ZERO;
            addr_q       <= {LINE_IDX_BITS{1'b0}};
            req_ready_q  <= 1'b0;
            data_ready_q <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_tag_q   <= {TAG_BITS{1'b0}};
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            addr_q       <= addr_d;
            req_ready_q  <= req_ready_d;
            data_ready_q <= data_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_tag_q   <= resp_tag_d;
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            ram[wr_idx_s] <= mem_req_data_bits;
        end
    end

    // Synchronous RAM read into the response data register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_data_q <= {DATA_BITS{1'b0}};
        end else if (rd_en_s) begin
            resp_data_q <= ram[rd_idx_s];
        end
    end

    assign mem_req_ready      = req_ready_q;
    assign mem_req_data_ready = data_ready_q;
    assign mem_resp_valid     = resp_valid_q;
    assign mem_resp_data      = resp_data_q;
    assign mem_resp_tag       = resp_tag_q;

endmodule : bram_mem

// File: tb/tb_bram_mem.sv
// -----------------------------------------------------------------------------
// tb_bram_mem
// Directed bench for bram_mem. A line-level reference model (associative word
// store plus a queue of expected response beats and a small idle/busy timer)
// predicts every output on every cycle; directed tests add literal checks.
// -----------------------------------------------------------------------------
module tb_bram_mem;
    import mem_pkg::*;

    localparam int AB = MEM_ADDR_BITS;
    localparam int TB = MEM_TAG_BITS;
    localparam int DB = MEM_DATA_BITS;
    localparam int RC = MEM_REFILL_CYCLES;
    localparam int LINES = 1 << MEM_LINE_IDX_BITS;

    logic          clk;
    logic          reset;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_req_rw;
    logic [AB-1:0] mem_req_addr;
    logic [TB-1:0] mem_req_tag;
    logic          mem_req_data_valid;
    logic          mem_req_data_ready;
    logic [DB-1:0] mem_req_data_bits;
    logic          mem_resp_valid;
    logic [DB-1:0] mem_resp_data;
    logic [TB-1:0] mem_resp_tag;

    bram_mem dut (
        .clk                (clk),
        .reset              (reset),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_rw         (mem_req_rw),
        .mem_req_addr       (mem_req_addr),
        .mem_req_tag        (mem_req_tag),
        .mem_req_data_valid (mem_req_data_valid),
        .mem_req_data_ready (mem_req_data_ready),
        .mem_req_data_bits  (mem_req_data_bits),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_data      (mem_resp_data),
        .mem_resp_tag       (mem_resp_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [TB-1:0] tag;
        logic [DB-1:0] data;
        bit            known;
    } beat_t;

    logic [DB-1:0] mm [int];     // word store, index = line*RC + beat
    beat_t         exp_q[$];     // response beats still owed
    beat_t         cap[$];       // beats observed (cleared by tests)
    int            m_busy;       // cycles left before command channel is free
    bit            m_wr;         // a write line is being collected
    int            m_wline;
    int            m_wbeat;
    bit            m_started;    // ready seen once after reset release
    logic [TB-1:0] m_last_tag;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            m_busy     = 0;
            m_wr       = 1'b0;
            m_wbeat    = 0;
            m_started  = 1'b0;
            m_last_tag = '0;
        end else begin
            if (m_wr) begin
                if (mem_req_data_valid) begin
                    mm[m_wline * RC + m_wbeat] = mem_req_data_bits;
                    m_wbeat++;
                    if (m_wbeat == RC) m_wr = 1'b0;
                end
            end else if (m_busy > 0) begin
                m_busy--;
            end else if (m_started && mem_req_valid) begin
                if (mem_req_rw) begin
                    m_wr    = 1'b1;
                    m_wline = int'(mem_req_addr) % LINES;
                    m_wbeat = 0;
                end else begin
                    m_busy     = RC;
                    m_last_tag = mem_req_tag;
                    for (int b = 0; b < RC; b++) begin
                        beat_t e;
                        int    idx;
                        idx     = (int'(mem_req_addr) % LINES) * RC + b;
                        e.tag   = mem_req_tag;
                        e.known = mm.exists(idx);
                        e.data  = e.known ? mm[idx] : '0;
                        exp_q.push_back(e);
                    end
                end
            end
            m_started = 1'b1;
        end
    end

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        bit exp_valid;
        exp_valid = (exp_q.size() > 0);
        chk("resp_valid", mem_resp_valid, exp_valid);
        chk("req_ready", mem_req_ready, m_started && !m_wr && (m_busy == 0));
        chk("data_ready", mem_req_data_ready, m_wr);
        chk("resp_tag", mem_resp_tag, exp_valid ? exp_q[0].tag : m_last_tag);
        if (!reset) chk("resp_data_in_reset", mem_resp_data, '0);
        if (exp_valid) begin
            beat_t e;
            if (exp_q[0].known) chk("resp_data", mem_resp_data, exp_q[0].data);
            e = exp_q.pop_front();
            e.data = mem_resp_data;
            e.tag  = mem_resp_tag;
            cap.push_back(e);
        end
    end

    // ---------------- stimulus ----------------
    task automatic write_line(input int addr, input int tag, input logic [RC-1:0][DB-1:0] w, input int gap_at);
        @(negedge clk);
        mem_req_valid = 1'b1; mem_req_rw = 1'b1;
        mem_req_addr = AB'(addr); mem_req_tag = TB'(tag);
        @(negedge clk);
        mem_req_valid = 1'b0;
        for (int b = 0; b < RC; b++) begin
            if (b == gap_at) begin
                mem_req_data_valid = 1'b0;
                @(negedge clk);
            end
            mem_req_data_valid = 1'b1;
            mem_req_data_bits  = w[b];
            @(negedge clk);
        end
        mem_req_data_valid = 1'b0;
        mem_req_data_bits  = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic read_line(input int addr, input int tag);
        cap.delete();
        @(negedge clk);
        mem_req_valid = 1'b1; mem_req_rw = 1'b0;
        mem_req_addr = AB'(addr); mem_req_tag = TB'(tag);
        @(negedge clk);
        mem_req_valid = 1'b0;
        repeat (RC + 1) @(negedge clk);
    endtask

    task automatic chk_cap(input string name, input int base, input int tag, input logic [RC-1:0][DB-1:0] w);
        chk({name, "_count"}, DB'(cap.size()), DB'(base + RC));
        if (cap.size() >= base + RC) begin
            for (int b = 0; b < RC; b++) begin
                chk({name, "_data"}, cap[base + b].data, w[b]);
                chk({name, "_tag"}, DB'(cap[base + b].tag), DB'(tag));
            end
        end
    endtask

    logic [RC-1:0][DB-1:0] l0, la, l6, l3old, l3mix;

    initial begin
        l0    = {128'h3, 128'h2, 128'h1, 128'h0};
        la    = {128'hA3, 128'hA2, 128'hA1, 128'hA0};
        l6    = {128'h63, 128'h62, 128'h61, 128'h60};
        l3old = {128'h33, 128'h32, 128'h31, 128'h30};
        l3mix = {128'h33, 128'h32, 128'hB1, 128'hB0};

        reset = 1'b0;
        mem_req_valid = 1'b0; mem_req_rw = 1'b0; mem_req_addr = '0; mem_req_tag = '0;
        mem_req_data_valid = 1'b0; mem_req_data_bits = '0;
        repeat (2) @(negedge clk);
        chk("reset_req_ready", mem_req_ready, 1'b0);
        chk("reset_resp_valid", mem_resp_valid, 1'b0);
        chk("reset_resp_tag", mem_resp_tag, '0);
        @(posedge clk); #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_req_ready", mem_req_ready, 1'b1);

        // 1: preload line 0 and read it back with tag 5
        write_line(0, 0, l0, -1);
        read_line(0, 5);
        chk_cap("t1", 0, 5, l0);
        chk("t1_ready_after", mem_req_ready, 1'b1);

        // 2: write line 7 with a gap, read with tag 9
        write_line(7, 2, la, 2);
        read_line(7, 9);
        chk_cap("t2", 0, 9, la);

        // 3: aliasing, 1030 maps to line 6
        write_line(6, 1, l6, -1);
        read_line(1030, 3);
        chk_cap("t3", 0, 3, l6);

        // 4/6: valid held through a burst -> two back-to-back bursts, tags 1 then 4
        cap.delete();
        @(negedge clk);
        mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = AB'(0); mem_req_tag = TB'(1);
        @(negedge clk);
        mem_req_addr = AB'(7); mem_req_tag = TB'(4);
        repeat (5) @(negedge clk);
        mem_req_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("t4_beats", DB'(cap.size()), DB'(2 * RC));
        if (cap.size() == 2 * RC) begin
            chk("t4_first_tag", DB'(cap[0].tag), DB'(1));
            chk("t4_last_data", cap[2 * RC - 1].data, 128'hA3);
            chk("t4_second_tag", DB'(cap[RC].tag), DB'(4));
        end

        // 4b: write data in IDLE is ignored
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_req_data_valid = 1'b1;
            mem_req_data_bits  = DB'(128'hDEAD_0000 + i);
        end
        @(negedge clk);
        mem_req_data_valid = 1'b0;
        read_line(0, 6);
        chk_cap("t4b", 0, 6, l0);

        // 5: reset after two beats of a write to line 3
        write_line(3, 7, l3old, -1);
        @(negedge clk);
        mem_req_valid = 1'b1; mem_req_rw = 1'b1; mem_req_addr = AB'(3); mem_req_tag = TB'(8);
        @(negedge clk);
        mem_req_valid = 1'b0;
        mem_req_data_valid = 1'b1; mem_req_data_bits = 128'hB0;
        @(negedge clk);
        mem_req_data_bits = 128'hB1;
        @(negedge clk);
        mem_req_data_valid = 1'b0;
        @(posedge clk); #2 reset = 1'b0;
        @(negedge clk);
        chk("t5_rst_req_ready", mem_req_ready, 1'b0);
        chk("t5_rst_data_ready", mem_req_data_ready, 1'b0);
        chk("t5_rst_resp_valid", mem_resp_valid, 1'b0);
        chk("t5_rst_resp_tag", mem_resp_tag, '0);
        chk("t5_rst_resp_data", mem_resp_data, '0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        read_line(3, 10);
        chk_cap("t5", 0, 10, l3mix);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "timeout");
    end

endmodule : tb_bram_mem

// File: doc/bram_mem.md
Name: bram_mem

Overview:
- Block-RAM backed memory model that serves the wide, tagged memory protocol: command channel, write-data channel and response channel.
- Sits behind the narrow-to-wide protocol converter as the backup memory.
- Every command addresses one cache line of REFILL_CYCLES data beats.
- Reads return all beats of the line with the command's tag. Writes consume all beats of the line and produce no response.

Parameters:
ADDR_BITS, 26, line address width (byte address = addr * 64)
TAG_BITS, 5, transaction tag width
DATA_BITS, 128, beat width
REFILL_CYCLES, 4, beats per line
LINE_IDX_BITS, 10, log2 of lines stored (DEPTH_LINES = 1024)

Ports:
clk  in  1  clock; all state changes on its rising edge
reset  in  1  asynchronous, active-low reset
mem_req_valid  in  1  command valid
mem_req_ready  out  1  command ready
mem_req_rw  in  1  1 = write, 0 = read
mem_req_addr  in  ADDR_BITS  line address
mem_req_tag  in  TAG_BITS  transaction tag
mem_req_data_valid  in  1  write beat valid
mem_req_data_ready  out  1  write beat ready
mem_req_data_bits  in  DATA_BITS  write beat data
mem_resp_valid  out  1  read beat valid; no backpressure
mem_resp_data  out  DATA_BITS  read beat data
mem_resp_tag  out  TAG_BITS  tag of the read being returned

Behaviour:
- Storage: unpacked array named ram, of DEPTH_LINES*REFILL_CYCLES words, each DATA_BITS wide.
  - Word index = {addr[LINE_IDX_BITS-1:0], beat[log2(REFILL_CYCLES)-1:0]}.
  - Upper address bits are ignored, so addresses alias modulo DEPTH_LINES.
  - The array must stay reachable hierarchically as ram for $readmemh preload. It is never cleared by reset.
- States:
  - IDLE: mem_req_ready=1.
  - READ: mem_req_ready=0, mem_req_data_ready=0.
  - WRITE: mem_req_data_ready=1, mem_req_ready=0.
- Reset (reset=0, async):
  - State goes to IDLE; beat counter 0; captured tag/addr 0.
  - mem_resp_valid=0, mem_resp_tag=0, mem_resp_data=0, mem_req_data_ready=0.
  - mem_req_ready is 1 only once reset deasserts.
  - Reset mid-transaction abandons it. Beats already written remain in ram.
- Command handshake (valid&&ready at edge E0, IDLE only): latch tag and addr; beat counter = 0; next state READ or WRITE per rw.
- READ:
  - Synchronous RAM read.
  - Beat k (k = 0..REFILL_CYCLES-1) is presented with mem_resp_valid=1, mem_resp_tag = latched tag, and data ram[{addr,k}] in cycle k+1 after E0, back-to-back.
  - The first cycle after the last beat returns to IDLE with mem_resp_valid=0.
  - A new command is accepted at the earliest in that cycle.
- WRITE:
  - Each edge with mem_req_data_valid=1 writes ram[{addr,beat}] = mem_req_data_bits and increments beat.
  - Gaps in data_valid are allowed.
  - After beat REFILL_CYCLES-1 is accepted, the next state is IDLE; data_ready drops the following cycle.
  - The write is visible to any later read.
- mem_req_data_valid outside WRITE is ignored; it is neither consumed nor stored.
- mem_req_valid outside IDLE is ignored.
- When mem_resp_valid=0, mem_resp_data is don't-care. mem_resp_tag holds its last value.
- mem_resp_valid is never asserted for writes.

Decomposition:
- Shared package mem_pkg:
  - state enum {IDLE, READ, WRITE};
  - default ADDR_BITS/TAG_BITS/DATA_BITS/REFILL_CYCLES constants;
  - beat-counter width function.
- No sub-module. The RAM array stays local so that the ram path remains valid for preload.

Test Plan:
1. Preload ram words 0..3 = 0x0..0x3. Issue read addr 0, tag 5 → resp_valid in 4 consecutive cycles, data 0,1,2,3, tag 5 each; req_ready back high after.
2. Write addr 7, tag 2, beats 0xA0..0xA3 with one idle gap between beats 1 and 2, then read addr 7, tag 9 → returns 0xA0..0xA3 with tag 9; no response ever produced for the write.
3. Read addr 1030 → returns line 6 contents (aliasing modulo 1024).
4. Hold mem_req_valid high during a read burst → second command is not accepted until the burst ends. Drive data_valid in IDLE → ram unchanged.
5. Assert reset after 2 beats of a write to addr 3, then read addr 3 → first 2 beats new, last 2 old; outputs 0 during reset.
6. Back-to-back reads tags 1 then 4 → 8 response beats, tag 1 then tag 4, one-cycle gap between bursts.
